// File: rtl/monitor_bateria_pkg.sv
// Shared types and helpers for the battery monitor: level and warning FSM encodings.
package monitor_bateria_pkg;

  typedef enum logic [1:0] {
    CRITICO   = 2'd0,
    REGULAR   = 2'd1,
    ACEPTABLE = 2'd2,
    OPTIMO    = 2'd3
  } nivel_t;

  typedef enum logic {
    NORMAL      = 1'b0,
    ADVERTENCIA = 1'b1
  } estado_adv_t;

  // Bit order {optimo, aceptable, regular, critico}
  function automatic logic [3:0] nivel_a_onehot(nivel_t n);
    return 4'b0001 << n;
  endfunction

endpackage

// File: rtl/filtro_advertencia.sv
// One channel's debounced, hysteretic low-charge warning FSM.
module filtro_advertencia
  import monitor_bateria_pkg::*;
#(
  parameter int CICLOS_FILTRO = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_p1,
  input  logic bajo_p1,
  input  logic alto_p1,
  output logic advertencia
);

  localparam int CW = $clog2(CICLOS_FILTRO + 1);

  estado_adv_t   estado;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_sig;
  logic          califica;
  logic          completo;

  function automatic logic [CW-1:0] inc_sat(logic [CW-1:0] c);
    return (c == CW'(CICLOS_FILTRO)) ? c : c + CW'(1);
  endfunction

  always_comb begin
    califica = (estado == NORMAL) ? bajo_p1 : alto_p1;
    cnt_sig  = inc_sat(cnt);
    completo = (cnt_sig == CW'(CICLOS_FILTRO));
  end

  // Stage 2: band readings fail both conditions, so they clear the count in either state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= NORMAL;
      cnt         <= '0;
      advertencia <= 1'b0;
    end else if (vld_p1) begin
      if (!califica) begin
        cnt <= '0;
      end else if (completo) begin
        cnt         <= '0;
        estado      <= (estado == NORMAL) ? ADVERTENCIA : NORMAL;
        advertencia <= (estado == NORMAL);
      end else begin
        cnt <= cnt_sig;
      end
    end
  end

endmodule

// File: rtl/monitorizacion_baterias_n.sv
// Registered battery monitor: per-channel warnings plus filtered four-level sum classification.
// Optional critical alarm enabled by defining ALARMA_CRITICA_EN.
module monitorizacion_baterias_n
  import monitor_bateria_pkg::*;
#(
  parameter int NUM_BAT          = 2,
  parameter int ANCHO_CARGA      = 4,
  parameter int UMBRAL_BAJO      = 3,
  parameter int HISTERESIS       = 2,
  parameter int CICLOS_FILTRO    = 4,
  parameter int UMBRAL_OPTIMO    = 24,
  parameter int UMBRAL_ACEPTABLE = 16,
  parameter int UMBRAL_REGULAR   = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         muestra_valida,
  input  logic [NUM_BAT*ANCHO_CARGA-1:0]               carga,
  output logic [NUM_BAT-1:0]                           advertencia_bateria,
  output logic                                         optimo,
  output logic                                         aceptable,
  output logic                                         regular,
  output logic                                         critico,
  output logic [ANCHO_CARGA+$clog2(NUM_BAT+1)-1:0]     carga_total,
`ifdef ALARMA_CRITICA_EN
  input  logic                                         borrar_alarma,
  output logic                                         alarma_critica,
`endif
  output logic                                         cambio_nivel
);

  localparam int W_SUMA = ANCHO_CARGA + $clog2(NUM_BAT + 1);
  localparam int CW     = $clog2(CICLOS_FILTRO + 1);

  logic [W_SUMA-1:0]      suma;
  logic [ANCHO_CARGA-1:0] lectura;
  logic [NUM_BAT-1:0]     bajo_c;
  logic [NUM_BAT-1:0]     alto_c;

  logic                   vld_p1;
  logic [NUM_BAT-1:0]     bajo_p1;
  logic [NUM_BAT-1:0]     alto_p1;
  nivel_t                 cand_p1;

  nivel_t                 nivel;
  nivel_t                 ultimo;
  logic [CW-1:0]          cnt_nivel;
  logic [CW-1:0]          cnt_nuevo;
  logic [3:0]             nivel_oh;
  logic                   salta;

  function automatic nivel_t clasificar(logic [W_SUMA-1:0] s);
    if (int'(s) >= UMBRAL_OPTIMO)         return OPTIMO;
    else if (int'(s) >= UMBRAL_ACEPTABLE) return ACEPTABLE;
    else if (int'(s) >= UMBRAL_REGULAR)   return REGULAR;
    else                                  return CRITICO;
  endfunction

  function automatic logic [CW-1:0] inc_sat(logic [CW-1:0] c);
    return (c == CW'(CICLOS_FILTRO)) ? c : c + CW'(1);
  endfunction

  always_comb begin
    suma    = '0;
    lectura = '0;
    bajo_c  = '0;
    alto_c  = '0;
    for (int i = 0; i < NUM_BAT; i++) begin
      lectura   = carga[i*ANCHO_CARGA +: ANCHO_CARGA];
      suma      = suma + W_SUMA'(lectura);
      bajo_c[i] = int'(lectura) < UMBRAL_BAJO;
      alto_c[i] = int'(lectura) >= UMBRAL_BAJO + HISTERESIS;
    end
  end

  // Stage 1: capture sum, compare flags and candidate level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      carga_total <= '0;
      bajo_p1     <= '0;
      alto_p1     <= '0;
      cand_p1     <= CRITICO;
    end else begin
      vld_p1 <= muestra_valida;
      if (muestra_valida) begin
        carga_total <= suma;
        bajo_p1     <= bajo_c;
        alto_p1     <= alto_c;
        cand_p1     <= clasificar(suma);
      end
    end
  end

  for (genvar g = 0; g < NUM_BAT; g++) begin : g_canal
    filtro_advertencia #(
      .CICLOS_FILTRO(CICLOS_FILTRO)
    ) u_filtro (
      .clk        (clk),
      .rst_n      (rst_n),
      .vld_p1     (vld_p1),
      .bajo_p1    (bajo_p1[g]),
      .alto_p1    (alto_p1[g]),
      .advertencia(advertencia_bateria[g])
    );
  end

  always_comb begin
    cnt_nuevo = (cand_p1 != ultimo) ? CW'(1) : inc_sat(cnt_nivel);
    salta     = vld_p1 && (cand_p1 != nivel) && (cnt_nuevo == CW'(CICLOS_FILTRO));
  end

  // Stage 2: level persistence filter; a jump may skip intermediate levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel        <= CRITICO;
      ultimo       <= CRITICO;
      cnt_nivel    <= '0;
      nivel_oh     <= 4'b0001;
      cambio_nivel <= 1'b0;
    end else begin
      cambio_nivel <= 1'b0;
      if (vld_p1) begin
        ultimo <= cand_p1;
        if (cand_p1 == nivel) begin
          cnt_nivel <= '0;
        end else if (salta) begin
          nivel        <= cand_p1;
          cnt_nivel    <= '0;
          nivel_oh     <= nivel_a_onehot(cand_p1);
          cambio_nivel <= 1'b1;
        end else begin
          cnt_nivel <= cnt_nuevo;
        end
      end
    end
  end

  assign {optimo, aceptable, regular, critico} = nivel_oh;

`ifdef ALARMA_CRITICA_EN
  // A fresh critical entry outranks a simultaneous clear request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarma_critica <= 1'b0;
    end else if (salta && (cand_p1 == CRITICO)) begin
      alarma_critica <= 1'b1;
    end else if (borrar_alarma) begin
      alarma_critica <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_monitorizacion_baterias_n.sv
// Scoreboard bench for monitorizacion_baterias_n with default parameters.
module tb_monitorizacion_baterias_n;

  typedef struct packed {
    logic [1:0] adv;
    logic [3:0] oh;
    logic       cam;
  } sal_t;

  localparam logic [3:0] CRIT = 4'b0001;
  localparam logic [3:0] ACC  = 4'b0100;
  localparam logic [3:0] OPT  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       muestra_valida;
  logic [7:0] carga;
  logic [1:0] advertencia_bateria;
  logic       optimo, aceptable, regular, critico;
  logic [5:0] carga_total;
  logic       cambio_nivel;
  logic       borrar_alarma;
`ifdef ALARMA_CRITICA_EN
  logic       alarma_critica;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sal_t       q_sal[$];
  logic [5:0] q_suma[$];
  logic [1:0] sr;

  always #5 clk = ~clk;

  monitorizacion_baterias_n dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .muestra_valida     (muestra_valida),
    .carga              (carga),
    .advertencia_bateria(advertencia_bateria),
    .optimo             (optimo),
    .aceptable          (aceptable),
    .regular            (regular),
    .critico            (critico),
    .carga_total        (carga_total),
`ifdef ALARMA_CRITICA_EN
    .borrar_alarma      (borrar_alarma),
    .alarma_critica     (alarma_critica),
`endif
    .cambio_nivel       (cambio_nivel)
  );

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] esp);
    n_cmp++;
    if (act !== esp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nombre, act, esp, $time);
    end
  endtask

  // Tracks which edges carried a sample, to know when each result is due
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= 2'b00;
    else        sr <= {sr[0], muestra_valida};
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (sr[0]) begin
        if (q_suma.size() == 0) chk("suma_underflow", 1, 0);
        else chk("carga_total", carga_total, q_suma.pop_front());
      end
      if (sr[1]) begin
        if (q_sal.size() == 0) chk("salida_underflow", 1, 0);
        else begin
          sal_t e;
          e = q_sal.pop_front();
          chk("advertencia", advertencia_bateria, e.adv);
          chk("nivel", {optimo, aceptable, regular, critico}, e.oh);
          chk("cambio_nivel", cambio_nivel, e.cam);
        end
      end else begin
        chk("cambio_idle", cambio_nivel, 0);
      end
    end
  end

  task automatic send(input int c0, input int c1, input logic [1:0] adv,
                      input logic [3:0] oh, input logic cam);
    sal_t e;
    @(negedge clk);
    muestra_valida = 1'b1;
    carga = {4'(c1), 4'(c0)};
    q_suma.push_back(6'(c0 + c1));
    e.adv = adv;
    e.oh  = oh;
    e.cam = cam;
    q_sal.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      muestra_valida = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_nivel", {optimo, aceptable, regular, critico}, CRIT);
    chk("rst_adv", advertencia_bateria, 0);
    chk("rst_total", carga_total, 0);
    chk("rst_cambio", cambio_nivel, 0);
`ifdef ALARMA_CRITICA_EN
    chk("rst_alarma", alarma_critica, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    muestra_valida = 1'b0;
    carga = '0;
    borrar_alarma = 1'b0;
    repeat (2) @(negedge clk);
    chk("ini_nivel", {optimo, aceptable, regular, critico}, CRIT);
    chk("ini_adv", advertencia_bateria, 0);
    chk("ini_total", carga_total, 0);
    rst_n = 1'b1;

    // three low samples, then a reset discards the partial count
    repeat (3) send(2, 15, 2'b00, CRIT, 1'b0);
    idle(3);
    do_reset();
    repeat (3) send(2, 15, 2'b00, CRIT, 1'b0);
    idle(2);
    send(2, 15, 2'b01, ACC, 1'b1);

    // hysteresis band holds the warning, value 5 clears it
    repeat (4) send(4, 15, 2'b01, ACC, 1'b0);
    repeat (3) send(5, 15, 2'b01, ACC, 1'b0);
    send(5, 15, 2'b00, ACC, 1'b0);
    idle(3);
    do_reset();

    // critico to optimo in one jump, valid gap does not break the count
    repeat (3) send(15, 15, 2'b00, CRIT, 1'b0);
    idle(1);
    send(15, 15, 2'b00, OPT, 1'b1);
    idle(3);
    do_reset();

    // alternating candidates never persist long enough
    repeat (4) begin
      send(5, 5, 2'b00, CRIT, 1'b0);
      send(9, 9, 2'b00, CRIT, 1'b0);
    end

    // drop to critico and recover
    repeat (3) send(15, 15, 2'b00, CRIT, 1'b0);
    send(15, 15, 2'b00, OPT, 1'b1);
    repeat (3) send(2, 2, 2'b00, OPT, 1'b0);
    send(2, 2, 2'b11, CRIT, 1'b1);
    idle(2);
`ifdef ALARMA_CRITICA_EN
    chk("alarma_set", alarma_critica, 1);
`endif
    repeat (3) send(15, 15, 2'b11, CRIT, 1'b0);
    send(15, 15, 2'b00, OPT, 1'b1);
    idle(3);
`ifdef ALARMA_CRITICA_EN
    chk("alarma_hold", alarma_critica, 1);
    borrar_alarma = 1'b1;
    @(negedge clk);
    borrar_alarma = 1'b0;
    chk("alarma_clear", alarma_critica, 0);
`endif

    idle(4);
    chk("q_sal_vacia", q_sal.size(), 0);
    chk("q_suma_vacia", q_suma.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
